// File: rtl/jk_reg_bank.sv
// WIDTH-bit JK/D/T/SR flip-flop bank with parallel load, enable and sticky SR fault.
// Define JK_TOG_CNT_EN to add the saturating change counter tog_cnt.
module jk_reg_bank #(
    parameter int              WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int              CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             illegal
`ifdef JK_TOG_CNT_EN
    ,
    output logic [CNT_W-1:0] tog_cnt
`endif
);

    typedef enum logic [1:0] {
        MODE_JK = 2'b00,
        MODE_D  = 2'b01,
        MODE_T  = 2'b10,
        MODE_SR = 2'b11
    } mode_e;

    mode_e            mode_q;
    logic [WIDTH-1:0] q_mode;
    logic [WIDTH-1:0] q_next;
    logic             sr_bad;
    logic             set_err;

    assign mode_q = mode_e'(mode);

    always_comb begin
        q_mode = q;
        for (int i = 0; i < WIDTH; i++) begin
            unique case (mode_q)
                MODE_JK: begin
                    unique case ({j[i], k[i]})
                        2'b01:   q_mode[i] = 1'b0;
                        2'b10:   q_mode[i] = 1'b1;
                        2'b11:   q_mode[i] = ~q[i];
                        default: q_mode[i] = q[i];
                    endcase
                end
                MODE_D:  q_mode[i] = j[i];
                MODE_T:  q_mode[i] = q[i] ^ j[i];
                MODE_SR: begin
                    // j=k=1 holds the bit; the fault is flagged separately
                    unique case ({j[i], k[i]})
                        2'b01:   q_mode[i] = 1'b0;
                        2'b10:   q_mode[i] = 1'b1;
                        default: q_mode[i] = q[i];
                    endcase
                end
                default: q_mode[i] = q[i];
            endcase
        end
    end

    always_comb begin
        q_next = q;
        if (load) begin
            q_next = load_val;
        end else if (en) begin
            q_next = q_mode;
        end
    end

    assign sr_bad  = (mode_q == MODE_SR) && (|(j & k));
    assign set_err = en && !load && sr_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= RESET_VAL;
            illegal <= 1'b0;
        end else begin
            q <= q_next;
            if (set_err) begin
                illegal <= 1'b1;
            end else if (clr_err) begin
                illegal <= 1'b0;
            end
        end
    end

    assign qn = ~q;

`ifdef JK_TOG_CNT_EN
    logic q_chg;

    assign q_chg = (q_next != q);

    // counts cycles with any change, sticks at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            tog_cnt <= '0;
        end else if (q_chg && (tog_cnt != {CNT_W{1'b1}})) begin
            tog_cnt <= tog_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed self-checking bench for jk_reg_bank (WIDTH=4, RESET_VAL=4'b1010, CNT_W=2).
module tb_jk_reg_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] j = 4'h0;
    logic [3:0] k = 4'h0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'h0;
    logic       clr_err = 1'b0;
    logic [3:0] q;
    logic [3:0] qn;
    logic       illegal;
`ifdef JK_TOG_CNT_EN
    logic [1:0] tog_cnt;
`endif

    int checks = 0;
    int errors = 0;

    jk_reg_bank #(
        .WIDTH(4),
        .RESET_VAL(4'b1010),
        .CNT_W(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .mode(mode),
        .j(j),
        .k(k),
        .load(load),
        .load_val(load_val),
        .clr_err(clr_err),
        .q(q),
        .qn(qn),
        .illegal(illegal)
`ifdef JK_TOG_CNT_EN
        ,
        .tog_cnt(tog_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; en = 0; load = 0; clr_err = 0;
        j = 4'h0; k = 4'h0; mode = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1; load = 1; load_val = 4'hF; en = 1; mode = 2'b00;
        j = 4'hF; k = 4'hF;
        step();
        step();
        checks++;
        if (q !== 4'b1010) begin
            errors++;
            $display("FAIL reset_q: got %b want %b", q, 4'b1010);
        end
        checks++;
        if (qn !== 4'b0101) begin
            errors++;
            $display("FAIL reset_qn: got %b want %b", qn, 4'b0101);
        end
        checks++;
        if (illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_illegal: got %b want 0", illegal);
        end
`ifdef JK_TOG_CNT_EN
        checks++;
        if (tog_cnt !== 2'd0) begin
            errors++;
            $display("FAIL reset_tog_cnt: got %0d want 0", tog_cnt);
        end
`endif
        idle();
    endtask

    task automatic test_jk();
        // load 0 first: one change, tog_cnt=1
        load = 1; load_val = 4'h0;
        step();
        load = 0;
        en = 1; mode = 2'b00; j = 4'b0011; k = 4'b0101;
        step();
        checks++;
        if (q !== 4'b0011) begin
            errors++;
            $display("FAIL jk_mixed: got %b want %b", q, 4'b0011);
        end
        j = 4'hF; k = 4'hF;
        step();
        checks++;
        if (q !== 4'b1100) begin
            errors++;
            $display("FAIL jk_toggle1: got %b want %b", q, 4'b1100);
        end
        step();
        checks++;
        if (q !== 4'b0011 || qn !== 4'b1100) begin
            errors++;
            $display("FAIL jk_toggle2: got q=%b qn=%b want q=0011 qn=1100", q, qn);
        end
`ifdef JK_TOG_CNT_EN
        checks++;
        if (tog_cnt !== 2'd3) begin
            errors++;
            $display("FAIL jk_tog_cnt: got %0d want 3", tog_cnt);
        end
`endif
        idle();
    endtask

    task automatic test_d_t();
        en = 1; mode = 2'b01; j = 4'b1001; k = 4'b0110;
        step();
        checks++;
        if (q !== 4'b1001) begin
            errors++;
            $display("FAIL d_mode: got %b want %b", q, 4'b1001);
        end
        mode = 2'b10; j = 4'b0110; k = 4'b1111;
        step();
        checks++;
        if (q !== 4'b1111) begin
            errors++;
            $display("FAIL t_mode: got %b want %b", q, 4'b1111);
        end
        en = 0; j = 4'hF;
        for (int n = 0; n < 3; n++) begin
            step();
            checks++;
            if (q !== 4'b1111) begin
                errors++;
                $display("FAIL en_hold%0d: got %b want %b", n, q, 4'b1111);
            end
        end
        idle();
    endtask

    task automatic test_sr();
        load = 1; load_val = 4'h0;
        step();
        load = 0;
        en = 1; mode = 2'b11; j = 4'b1100; k = 4'b0110;
        step();
        checks++;
        if (q !== 4'b1000 || illegal !== 1'b1) begin
            errors++;
            $display("FAIL sr_set: got q=%b illegal=%b want q=1000 illegal=1", q, illegal);
        end
        // mode change with en=0 must not clear the flag
        en = 0; mode = 2'b01; j = 4'h0; k = 4'h0;
        step();
        checks++;
        if (illegal !== 1'b1) begin
            errors++;
            $display("FAIL sr_sticky: got %b want 1", illegal);
        end
        en = 1; mode = 2'b11; clr_err = 1; j = 4'h0; k = 4'h0;
        step();
        checks++;
        if (illegal !== 1'b0 || q !== 4'b1000) begin
            errors++;
            $display("FAIL sr_clear: got q=%b illegal=%b want q=1000 illegal=0", q, illegal);
        end
        j = 4'b0001; k = 4'b0001;
        step();
        checks++;
        if (illegal !== 1'b1 || q !== 4'b1000) begin
            errors++;
            $display("FAIL sr_set_wins: got q=%b illegal=%b want q=1000 illegal=1", q, illegal);
        end
        // load blocks the set condition; clr_err still clears
        load = 1; load_val = 4'h3; j = 4'hF; k = 4'hF;
        step();
        checks++;
        if (illegal !== 1'b0 || q !== 4'h3) begin
            errors++;
            $display("FAIL sr_load: got q=%b illegal=%b want q=0011 illegal=0", q, illegal);
        end
        idle();
    endtask

    task automatic test_priority();
        en = 1; mode = 2'b00; j = 4'hF; k = 4'hF;
        load = 1; load_val = 4'h5;
        step();
        checks++;
        if (q !== 4'h5) begin
            errors++;
            $display("FAIL prio_load: got %h want 5", q);
        end
        rst = 1;
        step();
        checks++;
        if (q !== 4'b1010 || qn !== 4'b0101) begin
            errors++;
            $display("FAIL prio_rst: got q=%b qn=%b want q=1010 qn=0101", q, qn);
        end
        idle();
    endtask

    task automatic test_saturation();
        logic [3:0] exp_q [5];
        logic [1:0] exp_c [5];
        exp_q[0] = 4'b1011; exp_q[1] = 4'b1010; exp_q[2] = 4'b1011;
        exp_q[3] = 4'b1010; exp_q[4] = 4'b1011;
        exp_c[0] = 2'd1; exp_c[1] = 2'd2; exp_c[2] = 2'd3;
        exp_c[3] = 2'd3; exp_c[4] = 2'd3;
        rst = 1;
        step();
        rst = 0; en = 1; mode = 2'b10; j = 4'b0001;
        for (int n = 0; n < 5; n++) begin
            step();
            checks++;
            if (q !== exp_q[n]) begin
                errors++;
                $display("FAIL sat_q%0d: got %b want %b", n, q, exp_q[n]);
            end
`ifdef JK_TOG_CNT_EN
            checks++;
            if (tog_cnt !== exp_c[n]) begin
                errors++;
                $display("FAIL sat_cnt%0d: got %0d want %0d", n, tog_cnt, exp_c[n]);
            end
`endif
        end
        rst = 1;
        step();
        checks++;
        if (q !== 4'b1010) begin
            errors++;
            $display("FAIL sat_rst_q: got %b want 1010", q);
        end
`ifdef JK_TOG_CNT_EN
        checks++;
        if (tog_cnt !== 2'd0) begin
            errors++;
            $display("FAIL sat_rst_cnt: got %0d want 0", tog_cnt);
        end
`endif
        idle();
    endtask

    initial begin
        test_reset();
        test_jk();
        test_d_t();
        test_sr();
        test_priority();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
